// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC + req/ack instruction fetch feeding a 2-entry {pc, inst} buffer to decode.
// Define IF_BYPASS_EN to forward an ack straight to decode when the buffer is empty.
module inst_fetch_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_data,
    output logic [7:0]      inst,
    output logic [PC_W-1:0] inst_pc,
    output logic            inst_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic [PC_W-1:0] flush_pc,
    output logic            busy
);
    typedef enum logic {IDLE, REQ} state_t;
    state_t          state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d;
    logic [PC_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [7:0]      inst0_q, inst0_d, inst1_q, inst1_d;
    logic [1:0]      count_q, count_d;
    logic            drop_q, drop_d;
    logic            ack, byp, push, buf_pop, slot;

    always_comb begin
        ack        = state_q == REQ && imem_ack;
`ifdef IF_BYPASS_EN
        byp        = ack && count_q == 2'd0 && !drop_q && !flush;
`else
        byp        = 1'b0;
`endif
        buf_pop    = count_q != 2'd0 && !stall && !flush;
        push       = ack && !drop_q && !flush && !(byp && !stall);
        count_d    = flush ? 2'd0 : count_q + 2'(push) - 2'(buf_pop);
        fetch_pc_d = flush ? flush_pc : (ack && !drop_q) ? fetch_pc_q + 1'b1 : fetch_pc_q;
        drop_d     = (flush && state_q == REQ && !imem_ack) ? 1'b1 : ack ? 1'b0 : drop_q;
        // An unacked request can't be retracted, so it keeps its address even across a flush
        state_d    = ((state_q == REQ && !ack) || count_d != 2'd2) ? REQ : IDLE;
        addr_d     = (state_q == REQ && !ack) ? addr_q : (state_d == REQ) ? fetch_pc_d : addr_q;
        slot       = count_q[1] | (count_q[0] & ~buf_pop);
        pc0_d      = (buf_pop && count_q == 2'd2) ? pc1_q : pc0_q;
        inst0_d    = (buf_pop && count_q == 2'd2) ? inst1_q : inst0_q;
        pc1_d      = pc1_q;
        inst1_d    = inst1_q;
        if (push && !slot) begin
            pc0_d   = fetch_pc_q;
            inst0_d = imem_data;
        end
        if (push && slot) begin
            pc1_d   = fetch_pc_q;
            inst1_d = imem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            count_q    <= 2'd0;
            drop_q     <= 1'b0;
            pc0_q      <= '0;
            pc1_q      <= '0;
            inst0_q    <= 8'h00;
            inst1_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            pc0_q      <= pc0_d;
            pc1_q      <= pc1_d;
            inst0_q    <= inst0_d;
            inst1_q    <= inst1_d;
        end
    end

    assign imem_req   = state_q == REQ;
    assign busy       = state_q == REQ;
    assign imem_addr  = addr_q;
    assign inst_valid = count_q != 2'd0 || byp;
    assign inst       = byp ? imem_data : inst0_q;
    assign inst_pc    = byp ? addr_q : pc0_q;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: scoreboard bench for inst_fetch_unit with a behavioural instruction memory.
module tb_inst_fetch_unit;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       imem_req, imem_ack = 1'b0, inst_valid, stall = 1'b0, flush = 1'b0, busy;
    logic [7:0] imem_addr, imem_data = 8'h00, inst, inst_pc, flush_pc = 8'h00;
    logic [7:0] mem [256];
    logic [15:0] sb[$];
    logic [7:0] exp_pc;
    logic       drop;
    int         hold_addr = -1;
    int         n_cmp = 0, n_err = 0, n_pop = 0;
    bit         found;

    inst_fetch_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .inst(inst), .inst_pc(inst_pc),
        .inst_valid(inst_valid), .stall(stall), .flush(flush), .flush_pc(flush_pc),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs at negedge, let the memory answer, update the model, score pops.
    task automatic cycle(input logic st, input logic fl, input logic [7:0] fpc);
        logic [15:0] e;
        @(negedge clk);
        stall     = st;
        flush     = fl;
        flush_pc  = fpc;
        imem_ack  = imem_req && !reset && (int'(imem_addr) != hold_addr);
        imem_data = mem[imem_addr];
        #1;
        if (reset) begin
            sb.delete();
            drop   = 1'b0;
            exp_pc = 8'h00;
        end else begin
            if (imem_ack) begin
                if (drop) drop = 1'b0;
                else if (!fl) begin
                    check("fetch_addr", imem_addr, exp_pc);
                    sb.push_back({imem_addr, imem_data});
                    exp_pc++;
                end
            end
            if (fl) begin
                sb.delete();
                exp_pc = fpc;
                if (imem_req && !imem_ack) drop = 1'b1;
            end else if (inst_valid && !st) begin
                n_pop++;
                if (sb.size() == 0) check("spurious_valid", inst_valid, 0);
                else begin
                    e = sb.pop_front();
                    check("inst_pc_inst", {inst_pc, inst}, e);
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(0, 0, 8'h00);
        check("rst_req", imem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_inst", {inst_pc, inst}, 0);
        reset = 1'b0;
        hold_addr = -1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 8'h11);
        mem[0] = 8'h23; mem[1] = 8'h41; mem[2] = 8'hC5; mem[3] = 8'h99; mem[8'h10] = 8'h5C;

        // 1: free-running fetch with no stall
        do_reset();
        n_pop = 0;
        repeat (8) cycle(0, 0, 8'h00);
        check("t1_pops", 32'(n_pop >= 5), 1);

        // 2: stall until the buffer fills, then release
        do_reset();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1, 0, 8'h00);
            found = inst_valid;
        end
        check("t2_valid", found, 1);
        repeat (6) cycle(1, 0, 8'h00);
        check("t2_req_idle", imem_req, 0);
        check("t2_busy", busy, 0);
        check("t2_head", {inst_pc, inst}, 16'h0023);
        n_pop = 0;
        repeat (6) cycle(0, 0, 8'h00);
        check("t2_pops", 32'(n_pop >= 3), 1);

        // 3: flush while the request to addr 3 is held, ack arrives later and is dropped
        do_reset();
        hold_addr = 3;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(0, 0, 8'h00);
            found = imem_req && imem_addr == 8'h03;
        end
        check("t3_req3", found, 1);
        cycle(0, 1, 8'h40);
        cycle(0, 0, 8'h00);
        check("t3_addr_held", imem_addr, 8'h03);
        cycle(0, 0, 8'h00);
        hold_addr = -1;
        cycle(0, 0, 8'h00);
        check("t3_ack_seen", imem_ack, 1);
        repeat (6) cycle(0, 0, 8'h00);

        // 4: PC wrap from 0xFF
        cycle(0, 1, 8'hFF);
        n_pop = 0;
        repeat (6) cycle(0, 0, 8'h00);
        check("t4_pops", 32'(n_pop >= 3), 1);

        // 5: reset while a request is pending
        do_reset();
        hold_addr = 0;
        repeat (3) cycle(0, 0, 8'h00);
        check("t5_req_pend", imem_req, 1);
        reset = 1'b1;
        cycle(0, 0, 8'h00);
        check("t5_req", imem_req, 0);
        check("t5_valid", inst_valid, 0);
        check("t5_busy", busy, 0);
        reset = 1'b0;
        hold_addr = -1;
        repeat (4) cycle(0, 0, 8'h00);

        // 6: empty buffer, ack of 0x5C at 0x10
        do_reset();
        cycle(0, 1, 8'h10);
        cycle(0, 0, 8'h00);
        check("t6_ack", imem_ack, 1);
`ifdef IF_BYPASS_EN
        check("t6_byp_valid", inst_valid, 1);
        check("t6_byp_inst", {inst_pc, inst}, 16'h105C);
`else
        check("t6_valid_ack", inst_valid, 0);
        cycle(0, 0, 8'h00);
        check("t6_valid", inst_valid, 1);
        check("t6_inst", {inst_pc, inst}, 16'h105C);
`endif
        repeat (3) cycle(0, 0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
